spi_sclk_engine: RTL and testbench
==================================

# spi_sclk_engine

Parametrised SPI master clock engine that replaces the fixed four-tap divider with a programmable half-period divider, transfer framing, and per-bit phase tracking. It accepts a start request with a bit count, then generates exactly 2×N SCLK edges at the programmed rate with the correct CPOL idle level. It emits registered edge, sample and setup strobes, including the CPHA=0 leading setup and trailing-edge suppression. It sits between the SPI control registers and the shift-register/chip-select logic.

## Interface
- DIV_W, 8, width of the half-period divisor
- NB_W, 6, width of the bit-count input (max transfer 2^NB_W−1 bits)
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_div  in  DIV_W  half-period minus one in i_clk cycles; latched at start
- i_nbits  in  NB_W  bits per transfer; latched at start
- i_cpol, i_cpha  in  1  SPI mode; latched at start
- i_mstr  in  1  1 = master; 0 = engine inert
- i_start  in  1  single-cycle transfer request
- i_abort  in  1  terminate the transfer immediately
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse when a transfer completes normally
- o_sclk  out  1  SPI clock, registered
- o_sclk_oe  out  1  SCLK output enable (= i_mstr)
- o_rise, o_fall  out  1  one-cycle pulses in the same cycle o_sclk shows its new level
- o_sample, o_setup  out  1  one-cycle data sample and data setup strobes

## Operation
- States: IDLE, RUN, TAIL.
- IDLE:
  - o_sclk register loads i_cpol each cycle.
  - i_start with i_mstr=1, i_nbits≠0 and i_abort=0 → latch the inputs, clear the half-period counter and edge counter, go to RUN.
  - All other i_start cases are ignored.
- RUN:
  - The half-period counter runs 0..div_l.
  - At terminal count: toggle o_sclk, increment the edge index k (1..2N), clear the counter.
  - After edge 2N → TAIL.
- TAIL: wait div_l+1 cycles, then pulse o_done and go to IDLE.
- Edge role (odd k = leading, even k = trailing):
  - CPHA=0: o_sample on odd k. o_setup on even k, except k=2N. An extra o_setup is issued in the first RUN cycle.
  - CPHA=1: o_setup on odd k, o_sample on even k.
- o_rise and o_fall follow the absolute direction of o_sclk, independent of role.
- i_start while busy is ignored. Changes to i_div, i_cpol and i_cpha mid-transfer are ignored.
- i_abort in RUN or TAIL:
  - Next cycle: state IDLE, o_busy=0, o_sclk=cpol_l, no o_done, no strobes.
  - i_abort has priority over i_start.
- i_mstr=0: o_sclk_oe=0, start requests are ignored, and an active transfer is aborted.
- Arithmetic: the edge counter is NB_W+1 bits wide. The half-period counter is DIV_W bits and never wraps past div_l.

## Timing
- Reset values: state IDLE; o_sclk=0; o_busy, o_done, o_rise, o_fall, o_sample and o_setup all 0. o_sclk takes i_cpol one cycle after reset release.
- For a start sampled at edge T (H = div_l+1):
  - T+1: o_busy=1. o_setup=1 if CPHA=0.
  - Edge k appears at T+1+k·H, with its strobes in the same cycle.
  - o_done=1 and o_busy=0 at T+1+(2N+1)·H.
- A new start is accepted in the o_done cycle, since the state is already IDLE.
- Minimum SCLK period is 2 i_clk cycles (i_div=0).
- All outputs are registered except o_sclk_oe.

## Structure
- Package spi_pkg: state enum (IDLE/RUN/TAIL) and SPI mode constants (MODE0..MODE3 as {cpol,cpha}).
- Sub-module spi_half_period_timer: counter with load, clear and terminal-count tick, parameterised by DIV_W.
- The FSM, edge counter and strobe decode stay in spi_sclk_engine.

## Test plan
- Mode 0, i_div=0, i_nbits=8:
  - 16 edges at T+2..T+17; first edge rising.
  - o_setup at T+1 and on falling edges 2..14 only (none at edge 16); o_sample on 8 rising edges.
  - o_done at T+18.
- Mode 3, i_div=3, i_nbits=4:
  - Idle high; 8 edges spaced 4 cycles apart; first edge falling.
  - o_setup on falls, o_sample on rises; o_done at T+37.
- Mode 1 and mode 2, i_nbits=1:
  - Exactly two edges.
  - Setup on the first edge, sample on the second.
- Abort at the third edge of a 16-bit transfer:
  - Next cycle: o_busy=0, o_sclk=cpol_l, no o_done.
  - A subsequent start runs a full transfer.
- Ignored requests:
  - i_start while busy has no effect.
  - i_nbits=0 or i_mstr=0 with i_start leaves o_busy=0.
  - i_mstr=0 gives o_sclk_oe=0.
- Reset asserted mid-RUN: next cycle all outputs at their reset values.
- Random i_div and i_nbits regression: total edge count equals 2N, and the edge spacing is constant.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI clock engine.
package spi_pkg;

  // Transfer framing states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StTail
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] Mode0 = 2'b00;
  localparam logic [1:0] Mode1 = 2'b01;
  localparam logic [1:0] Mode2 = 2'b10;
  localparam logic [1:0] Mode3 = 2'b11;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period counter: counts 0..div (div latched on load), ticks at terminal count.
module spi_half_period_timer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  input  logic             i_en,
  output logic             o_tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign o_tick = i_en && (cnt_q == div_q);

  // Next count: clear wins, otherwise advance and wrap to zero at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter and latched divisor registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (i_load) begin
        div_q <= i_div;
      end
    end
  end

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK engine: frames a transfer of 2N edges at a programmable rate and
// emits registered edge, sample and setup strobes.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned NB_W  = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [DIV_W-1:0] i_div,
  input  logic [NB_W-1:0]  i_nbits,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic             i_mstr,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_sclk_oe,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_sample,
  output logic             o_setup
);

  spi_state_e state_q, state_d;
  logic [NB_W:0]   edge_q, edge_d;
  logic [NB_W:0]   k_next;
  logic [NB_W:0]   two_n;
  logic [NB_W-1:0] nbits_q;
  logic            cpol_q, cpha_q;
  logic            sclk_q, sclk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            sample_q, sample_d;
  logic            setup_q, setup_d;
  logic            tmr_load, tmr_clear, tmr_en, tick;
  logic            start_ok, stop;

  spi_half_period_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_load (tmr_load),
    .i_div  (i_div),
    .i_clear(tmr_clear),
    .i_en   (tmr_en),
    .o_tick (tick)
  );

  assign start_ok  = i_start && i_mstr && (i_nbits != '0) && !i_abort;
  // Losing master mode kills an active transfer just like an explicit abort.
  assign stop      = i_abort || !i_mstr;
  assign two_n     = {nbits_q, 1'b0};
  assign k_next    = edge_q + 1'b1;
  assign o_sclk_oe = i_mstr;

  // Framing FSM, edge counter and strobe decode.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    sample_d  = 1'b0;
    setup_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d    = i_cpol;
        busy_d    = 1'b0;
        tmr_clear = 1'b1;
        if (start_ok) begin
          state_d  = StRun;
          busy_d   = 1'b1;
          edge_d   = '0;
          tmr_load = 1'b1;
          // CPHA=0 needs the first bit on the wire before the leading edge.
          setup_d  = ~i_cpha;
        end
      end
      StRun: begin
        if (stop) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          sclk_d    = cpol_q;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tick) begin
            sclk_d = ~sclk_q;
            rise_d = ~sclk_q;
            fall_d = sclk_q;
            edge_d = k_next;
            // Odd k is the leading edge of a bit, even k the trailing edge.
            if (cpha_q) begin
              setup_d  = k_next[0];
              sample_d = ~k_next[0];
            end else begin
              sample_d = k_next[0];
              setup_d  = ~k_next[0] && (k_next != two_n);
            end
            if (k_next == two_n) begin
              state_d = StTail;
            end
          end
        end
      end
      StTail: begin
        if (stop) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          sclk_d    = cpol_q;
          tmr_clear = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tick) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latched transfer settings and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      edge_q   <= '0;
      nbits_q  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sample_q <= 1'b0;
      setup_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sample_q <= sample_d;
      setup_q  <= setup_d;
      if (tmr_load) begin
        nbits_q <= i_nbits;
        cpol_q  <= i_cpol;
        cpha_q  <= i_cpha;
      end
    end
  end

  assign o_sclk   = sclk_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_rise   = rise_q;
  assign o_fall   = fall_q;
  assign o_sample = sample_q;
  assign o_setup  = setup_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: timeline model checked every cycle, plus directed literal checks.
module tb_spi_sclk_engine;
  import spi_pkg::*;

  localparam int DIV_W = 8;
  localparam int NB_W  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic [NB_W-1:0]  nbits;
  logic             cpol, cpha, mstr, start, abort;
  logic             busy, done, sclk, sclk_oe, rise, fall, sample, setup;

  spi_sclk_engine #(
    .DIV_W(DIV_W),
    .NB_W (NB_W)
  ) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_div    (div),
    .i_nbits  (nbits),
    .i_cpol   (cpol),
    .i_cpha   (cpha),
    .i_mstr   (mstr),
    .i_start  (start),
    .i_abort  (abort),
    .o_busy   (busy),
    .o_done   (done),
    .o_sclk   (sclk),
    .o_sclk_oe(sclk_oe),
    .o_rise   (rise),
    .o_fall   (fall),
    .o_sample (sample),
    .o_setup  (setup)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- timeline model ----------------
  // A transfer accepted at edge T is described by its offset d from T:
  // busy over 1 <= d < 1+(2N+1)H, edge k at d = 1+k*H, done at d = 1+(2N+1)H.
  bit m_valid = 0, m_active = 0, m_new = 0;
  int m_d, m_h, m_n;
  bit m_cpol, m_cpha;
  bit e_busy, e_done, e_sclk, e_rise, e_fall, e_sample, e_setup;

  task automatic clear_strobes();
    e_done = 0; e_rise = 0; e_fall = 0; e_sample = 0; e_setup = 0;
  endtask

  task automatic predict(input int d);
    int  endd, k;
    bit  at_edge, leading;
    clear_strobes();
    endd = 1 + (2 * m_n + 1) * m_h;
    if (d == endd) begin
      e_done = 1; e_busy = 0; e_sclk = m_cpol; m_active = 0;
    end else begin
      e_busy  = 1;
      k       = (d - 1) / m_h;
      at_edge = ((d - 1) % m_h == 0) && (k >= 1) && (k <= 2 * m_n);
      e_sclk  = m_cpol ^ ((k % 2) != 0);
      leading = (k % 2) != 0;
      e_rise  = at_edge && e_sclk;
      e_fall  = at_edge && !e_sclk;
      if (at_edge) begin
        if (m_cpha) begin
          e_setup = leading; e_sample = !leading;
        end else begin
          e_sample = leading; e_setup = !leading && (k != 2 * m_n);
        end
      end
      if (d == 1 && !m_cpha) e_setup = 1;
    end
  endtask

  task automatic model_step();
    cyc++;
    m_valid = 1;
    if (rst) begin
      m_active = 0; e_busy = 0; e_sclk = 0; clear_strobes();
    end else if (m_active) begin
      if (abort || !mstr) begin
        m_active = 0; e_busy = 0; e_sclk = m_cpol; clear_strobes();
      end else begin
        m_d++;
        predict(m_d);
      end
    end else begin
      e_busy = 0; e_sclk = cpol; clear_strobes();
      if (start && mstr && nbits != 0 && !abort) begin
        m_active = 1; m_new = 1; m_d = 1;
        m_h = int'(div) + 1; m_n = int'(nbits); m_cpol = cpol; m_cpha = cpha;
        predict(1);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process ----------------
  int dut_edges = 0, last_edge = -1;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk_vec("outputs{busy,done,sclk,oe,rise,fall,sample,setup}",
              {busy, done, sclk, sclk_oe, rise, fall, sample, setup},
              {e_busy, e_done, e_sclk, mstr, e_rise, e_fall, e_sample, e_setup});
      if (m_new) begin
        dut_edges = 0; last_edge = -1; m_new = 0;
      end
      if (busy && (rise || fall)) begin
        if (last_edge >= 0) chk("edge_spacing", cyc - last_edge, m_h);
        last_edge = cyc;
        dut_edges++;
      end
      if (e_done) chk("edge_total", dut_edges, 2 * m_n);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_xfer(input int dv, input int nb, input logic [1:0] mode, input int x_done,
                          input int x_edges, input int x_setups, input int x_samples,
                          input int x_first_rise, input string tag);
    int setups = 0, samples = 0, edges = 0, done_at = -1, first_rise = -1;
    @(posedge clk); #1;
    div = DIV_W'(dv); nbits = NB_W'(nb); cpol = mode[1]; cpha = mode[0]; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int d = 1; d <= 4000 && done_at < 0; d++) begin
      @(negedge clk);
      if (setup) setups++;
      if (sample) samples++;
      if (rise || fall) begin
        if (first_rise < 0) first_rise = int'(rise);
        edges++;
      end
      if (done) done_at = d;
    end
    chk({tag, " done_offset"}, done_at, x_done);
    chk({tag, " edges"}, edges, x_edges);
    chk({tag, " setups"}, setups, x_setups);
    chk({tag, " samples"}, samples, x_samples);
    chk({tag, " first_edge_rising"}, first_rise, x_first_rise);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int edges, d, done_at, r;
    rst = 1; div = '0; nbits = '0; cpol = 0; cpha = 0; mstr = 1; start = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_vec("reset_outputs", {busy, done, sclk, rise, fall, sample, setup, 1'b0}, 8'h00);
    rst = 0;

    // Literal pins of the model's timing.
    run_xfer(0, 8, Mode0, 18, 16, 8, 8, 1, "mode0_div0_n8");
    run_xfer(3, 4, Mode3, 37, 8, 4, 4, 0, "mode3_div3_n4");
    run_xfer(2, 1, Mode1, 10, 2, 1, 1, 1, "mode1_n1");
    run_xfer(1, 1, Mode2, 7, 2, 1, 1, 0, "mode2_n1");

    // Abort at the third edge; i_cpol changes so cpol_l is distinguishable.
    @(posedge clk); #1;
    div = 1; nbits = 16; cpol = 1; cpha = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    edges = 0;
    for (int i = 0; i < 200 && edges < 3; i++) begin
      @(negedge clk);
      if (rise || fall) edges++;
    end
    chk("abort reach_edge3", edges, 3);
    abort = 1; cpol = 0;
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    chk("abort busy", int'(busy), 0);
    chk("abort sclk_is_cpol_l", int'(sclk), 1);
    chk("abort done", int'(done), 0);
    run_xfer(0, 2, Mode0, 6, 4, 2, 2, 1, "after_abort");

    // Start while busy, with settings changed mid-transfer.
    @(posedge clk); #1;
    div = 2; nbits = 3; cpol = 0; cpha = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    done_at = -1; d = 1;
    repeat (4) begin @(negedge clk); d++; end
    start = 1; nbits = 5; div = 0; cpol = 1; cpha = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 400 && done_at < 0; i++) begin
      @(negedge clk);
      if (done) done_at = d;
      d++;
    end
    chk("busy_start_ignored done_offset", done_at, 22);

    // Ignored starts.
    @(posedge clk); #1;
    nbits = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("nbits0 busy", int'(busy), 0);
    @(posedge clk); #1;
    nbits = 4; mstr = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("mstr0 busy", int'(busy), 0);
    chk("mstr0 sclk_oe", int'(sclk_oe), 0);
    @(posedge clk); #1;
    mstr = 1;

    // Reset mid-RUN.
    @(posedge clk); #1;
    div = 1; nbits = 8; cpol = 1; cpha = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_vec("reset_midrun", {busy, done, sclk, rise, fall, sample, setup, 1'b0}, 8'h00);
    @(negedge clk);
    chk("reset_release sclk_follows_cpol", int'(sclk), 1);

    // Random regression with occasional aborts, mode drops and stray starts.
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      div   = DIV_W'($urandom_range(0, 5));
      nbits = ($urandom_range(0, 9) == 0) ? NB_W'(63) : NB_W'($urandom_range(1, 24));
      {cpol, cpha} = 2'($urandom_range(0, 3));
      mstr  = 1; start = 1; abort = 0;
      for (int c = 0; c < 6000; c++) begin
        @(posedge clk); #1;
        start = 0; abort = 0; mstr = 1;
        if (!busy) break;
        r = $urandom_range(0, 999);
        if (r < 3) abort = 1;
        else if (r < 5) mstr = 0;
        else if (r < 60) begin
          start = 1;
          div   = DIV_W'($urandom);
          nbits = NB_W'($urandom);
          cpol  = 1'($urandom);
          cpha  = 1'($urandom);
        end
      end
      start = 0; abort = 0; mstr = 1;
      repeat (2) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
